uart_cmd_decoder: RTL and testbench

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_decoder.sv | 196 +++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Opcode constants and FSM state type for the UART command
//               decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    localparam logic [7:0] OP_INC        = 8'h81;
    localparam logic [7:0] OP_READ_COUNT = 8'h82;
    localparam logic [3:0] OP_WRITE      = 4'hA;
    localparam logic [3:0] OP_READ       = 4'hC;
    localparam logic [7:0] OP_ACK        = 8'h06;
    localparam logic [7:0] DIGIT_LO      = 8'h30;
    localparam logic [7:0] DIGIT_HI      = 8'h39;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ARG = 2'd1,
        SEND     = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Byte-stream command decoder sitting between uart_rx and
//               uart_tx. Maintains a small register file, a command counter
//               and a saturating protocol-error counter.
//               Optional feature macro: UART_CMD_WRITE_ACK_EN -- when defined,
//               every completed register write is acknowledged with 0x06.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int NUM_REGS     = 4,
    parameter int TIMEOUT_CLKS = 50_000_000/9600*20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [NUM_REGS*8-1:0] regs_flat,
    output logic [7:0]            count,
    output logic [7:0]            err_count,
    output logic                  busy
);

    localparam int                c_timer_w    = $clog2(TIMEOUT_CLKS);
    localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT_CLKS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_timer_w-1:0] r_timer;
    logic [3:0]           r_idx;
    logic [7:0]           r_tx_data;
    logic [7:0]           r_count;
    logic [7:0]           r_err;

    logic                 w_accept;
    logic                 w_idx_ok;
    logic [7:0]           w_rd_data;
    logic                 w_inc_count;
    logic                 w_inc_err;
    logic                 w_wr_en;
    logic [3:0]           w_wr_idx;
    logic [7:0]           w_wr_data;
    logic                 w_latch_idx;
    logic                 w_tx_load;
    logic [7:0]           w_tx_next;

    assign rx_ready  = (r_state != SEND);
    assign busy      = (r_state != IDLE);
    assign tx_valid  = (r_state == SEND);
    assign tx_data   = r_tx_data;
    assign count     = r_count;
    assign err_count = r_err;

    assign w_accept  = rx_valid && rx_ready;
    assign w_idx_ok  = (int'(rx_data[3:0]) < NUM_REGS);

    // Register file: one byte per entry, written by digit or write commands
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [7:0] r_reg;
            // Capture the write data when this entry is addressed
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_reg <= '0;
                end else if (w_wr_en && (w_wr_idx == 4'(gi))) begin
                    r_reg <= w_wr_data;
                end
            end
            assign regs_flat[8*gi +: 8] = r_reg;
        end
    endgenerate

    // Read mux selecting the register addressed by the low nibble of rx_data
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_data[3:0] == 4'(i)) begin
                w_rd_data = regs_flat[8*i +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command decode: next state plus one-cycle action strobes
    always_comb begin
        w_state_next = r_state;
        w_inc_count  = 1'b0;
        w_inc_err    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_idx     = '0;
        w_wr_data    = '0;
        w_latch_idx  = 1'b0;
        w_tx_load    = 1'b0;
        w_tx_next    = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (rx_data == OP_INC) begin
                        w_inc_count = 1'b1;
                    end else if (rx_data == OP_READ_COUNT) begin
                        w_tx_load    = 1'b1;
                        w_tx_next    = r_count;
                        w_state_next = SEND;
                    end else if ((rx_data >= DIGIT_LO) && (rx_data <= DIGIT_HI)) begin
                        w_wr_en   = 1'b1;
                        w_wr_idx  = '0;
                        w_wr_data = rx_data - DIGIT_LO;
                    end else if ((rx_data[7:4] == OP_WRITE) && w_idx_ok) begin
                        w_latch_idx  = 1'b1;
                        w_state_next = WAIT_ARG;
                    end else if ((rx_data[7:4] == OP_READ) && w_idx_ok) begin
                        w_tx_load    = 1'b1;
                        w_tx_next    = w_rd_data;
                        w_state_next = SEND;
                    end else begin
                        w_inc_err = 1'b1;
                    end
                end
            end
            WAIT_ARG: begin
                // An accepted payload takes priority over a simultaneous timeout
                if (w_accept) begin
                    w_wr_en      = 1'b1;
                    w_wr_idx     = r_idx;
                    w_wr_data    = rx_data;
`ifdef UART_CMD_WRITE_ACK_EN
                    w_tx_load    = 1'b1;
                    w_tx_next    = OP_ACK;
                    w_state_next = SEND;
`else
                    w_state_next = IDLE;
`endif
                end else if (r_timer == c_timer_last) begin
                    w_inc_err    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: counters, latched write index, reply byte and payload timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= '0;
            r_err     <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_timer   <= '0;
        end else begin
            if (w_inc_count) begin
                r_count <= r_count + 8'd1;
            end
            if (w_inc_err && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
            if (w_latch_idx) begin
                r_idx <= rx_data[3:0];
            end
            if (w_tx_load) begin
                r_tx_data <= w_tx_next;
            end
            if (r_state == WAIT_ARG) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Self-checking bench for uart_cmd_decoder (NUM_REGS = 4,
//               short payload timeout). Honours UART_CMD_WRITE_ACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_cmd_decoder;

    localparam int NREGS = 4;
    localparam int TOUT  = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [NREGS*8-1:0] regs_flat;
    logic [7:0]       count;
    logic [7:0]       err_count;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state derived from the command rules
    logic [7:0] m_regs [NREGS];
    logic [7:0] m_count;
    logic [7:0] m_err;

    uart_cmd_decoder #(
        .NUM_REGS     (NREGS),
        .TIMEOUT_CLKS (TOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .regs_flat (regs_flat),
        .count     (count),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] f = '0;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    function automatic bit is_bad(input logic [7:0] b);
        if (b == 8'h81 || b == 8'h82) return 1'b0;
        if (b >= 8'h30 && b <= 8'h39) return 1'b0;
        if ((b[7:4] == 4'hA || b[7:4] == 4'hC) && int'(b[3:0]) < NREGS) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_count = 8'h00;
        m_err   = 8'h00;
    endtask

    task automatic model_err();
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_regs"},  regs_flat, model_flat());
        chk({tag, "_count"}, count, m_count);
        chk({tag, "_err"},   err_count, m_err);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_txv"},   tx_valid, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_txv"},   tx_valid, 1'b0);
        chk({tag, "_txd"},   tx_data, 8'h00);
        chk({tag, "_regs"},  regs_flat, 32'h0);
        chk({tag, "_count"}, count, 8'h00);
        chk({tag, "_err"},   err_count, 8'h00);
        chk({tag, "_busy"},  busy, 1'b0);
        chk({tag, "_rxr"},   rx_ready, 1'b1);
    endtask

    // Present one byte; returns at the negedge after it has been accepted
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_ready_wait", rx_ready, 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Wait for a reply, stall it briefly, then complete the handshake
    task automatic expect_reply(input logic [7:0] exp, input string tag);
        int n = 0;
        int stall;
        while (tx_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, tx_valid, 1'b1);
        stall = $urandom_range(0, 3);
        repeat (stall) begin
            @(negedge clk);
            chk({tag, "_held"}, tx_valid, 1'b1);
        end
        chk(tag, tx_data, exp);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({tag, "_done"}, tx_valid, 1'b0);
    endtask

    task automatic after_write();
`ifdef UART_CMD_WRITE_ACK_EN
        expect_reply(8'h06, "ack");
`endif
    endtask

    // Issue one command byte (plus payload for writes) and update the model
    task automatic do_cmd(input logic [7:0] b);
        logic [7:0] p;
        int idx;
        idx = int'(b[3:0]);
        send_byte(b);
        if (b == 8'h81) begin
            m_count = m_count + 8'd1;
        end else if (b == 8'h82) begin
            expect_reply(m_count, "rd_count");
        end else if (b >= 8'h30 && b <= 8'h39) begin
            m_regs[0] = b - 8'h30;
        end else if (b[7:4] == 4'hA && idx < NREGS) begin
            p = 8'($urandom);
            send_byte(p);
            m_regs[idx] = p;
            after_write();
        end else if (b[7:4] == 4'hC && idx < NREGS) begin
            expect_reply(m_regs[idx], "rd_reg");
        end else begin
            model_err();
        end
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] cnt_before;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("reset");

        // Counter wrap: 257 increments leave count at 1
        repeat (257) do_cmd(8'h81);
        chk("inc257_count", count, 8'h01);
        do_cmd(8'h82);
        check_all("rdcount");

        // Write then read back register 2
        send_byte(8'hA2);
        send_byte(8'h5A);
        m_regs[2] = 8'h5A;
        after_write();
        chk("wr2_reg", regs_flat[23:16], 8'h5A);
        do_cmd(8'hC2);
        check_all("rd2");

        // Back-pressure: reply stalled while an increment waits on rx
        send_byte(8'hC0);
        cnt_before = m_count;
        rx_data  = 8'h81;
        rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_txv",   tx_valid, 1'b1);
            chk("bp_rxr",   rx_ready, 1'b0);
            chk("bp_count", count, cnt_before);
            chk("bp_txd",   tx_data, m_regs[0]);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk("bp_release_txv", tx_valid, 1'b0);
        chk("bp_release_count", count, cnt_before);
        @(negedge clk);
        rx_valid = 1'b0;
        m_count = m_count + 8'd1;
        chk("bp_after_count", count, cnt_before + 8'd1);
        check_all("bp");

        // Payload timeout
        send_byte(8'hA1);
        repeat (TOUT - 1) @(negedge clk);
        chk("to_pre_busy", busy, 1'b1);
        @(negedge clk);
        model_err();
        chk("to_busy", busy, 1'b0);
        chk("to_err", err_count, 8'h01);
        chk("to_reg1", regs_flat[15:8], 8'h00);
        check_all("timeout");

        // Payload arriving on the expiry cycle wins
        send_byte(8'hA1);
        repeat (TOUT - 1) @(negedge clk);
        rx_data  = 8'h77;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        m_regs[1] = 8'h77;
        after_write();
        chk("exp_reg1", regs_flat[15:8], 8'h77);
        chk("exp_err", err_count, 8'h01);
        check_all("expiry");

        // Randomized command mix
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: b = 8'h81;
                1: b = 8'h82;
                2: b = 8'h30 + 8'($urandom_range(0, 9));
                3: b = {4'hA, 4'($urandom_range(0, 5))};
                4: b = {4'hC, 4'($urandom_range(0, 5))};
                default: b = 8'($urandom);
            endcase
            do_cmd(b);
            check_all("rand");
        end

        // Out-of-range write index is an error; 0x33 is then a digit
        cnt_before = m_err;
        do_cmd(8'hA7);
        chk("a7_err", err_count, (cnt_before == 8'hFF) ? 8'hFF : cnt_before + 8'd1);
        do_cmd(8'h33);
        chk("digit_reg0", regs_flat[7:0], 8'h03);
        check_all("a7");

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            b = 8'($urandom);
            while (!is_bad(b)) b = 8'($urandom);
            do_cmd(b);
        end
        chk("err_sat", err_count, 8'hFF);
        check_all("sat");

        // Reset while a reply is pending
        send_byte(8'hC1);
        @(negedge clk);
        chk("rst_pre_txv", tx_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_reset("rst_send");
        reset = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("rst_after_rxr", rx_ready, 1'b1);
        chk("rst_after_busy", busy, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_txv", tx_valid, 1'b0);
        end
        tx_ready = 1'b0;
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
